// File: rtl/moore_tx_pkg.sv
// moore_tx_pkg: shared states and framing constants for the 1011 frame transmitter
package moore_tx_pkg;
    typedef enum logic [2:0] {TX_IDLE, TX_PRE, TX_PAY, TX_STUFF, TX_GUARD} tx_state_e;
    localparam logic [3:0] PREAMBLE      = 4'b1011;
    localparam int         PREAMBLE_LEN  = 4;
    localparam logic [2:0] STUFF_TRIGGER = 3'b101;
endpackage

// File: rtl/moore_seq_tx.sv
// moore_seq_tx: bit-serial 1011-preamble frame transmitter with payload bit stuffing
module moore_seq_tx
    import moore_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             serial_o,
    output logic             stuff_o,
    output logic             busy_o,
    output logic             frame_done_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = WIDTH + PREAMBLE_LEN - 1;
    tx_state_e         state_q, state_d;
    logic [SW-1:0]     sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        pre_q, pre_d;
    logic [2:0]        hist_q, hist_d;
    logic              serial_q, serial_d;
    logic              stuff_q, stuff_d;
    logic              done_q, done_d;
    assign ready_o      = state_q == TX_IDLE;
    assign busy_o       = state_q != TX_IDLE;
    assign serial_o     = serial_q;
    assign stuff_o      = stuff_q;
    assign frame_done_o = done_q;
    // Pick the next state together with the line bit it drives, so serial_o always shows the bit of state_q
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        serial_d = 1'b0;
        stuff_d  = 1'b0;
        done_d   = 1'b0;
        if (state_q == TX_IDLE) begin
            if (valid_i) begin
                state_d  = TX_PRE;
                serial_d = PREAMBLE[PREAMBLE_LEN-1];
                sr_d     = {PREAMBLE[PREAMBLE_LEN-2:0], data_i};
                cnt_d    = CW'(WIDTH);
                pre_d    = 2'd0;
            end
        end else if (state_q == TX_GUARD) begin
            state_d = TX_IDLE;
        end else if (state_q == TX_PRE && pre_q != 2'(PREAMBLE_LEN - 1)) begin
            serial_d = sr_q[SW-1];
            sr_d     = {sr_q[SW-2:0], 1'b0};
            pre_d    = pre_q + 2'd1;
        end else if (cnt_q == '0) begin
            state_d = TX_GUARD;
            done_d  = 1'b1;
        end else if (hist_q == STUFF_TRIGGER) begin
            state_d = TX_STUFF;
            stuff_d = 1'b1;
        end else begin
            state_d  = TX_PAY;
            serial_d = sr_q[SW-1];
            sr_d     = {sr_q[SW-2:0], 1'b0};
            cnt_d    = cnt_q - CW'(1);
        end
        hist_d = {hist_q[1:0], serial_d};
    end
    // State and registered line outputs; reset aborts any frame at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= TX_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            pre_q    <= '0;
            hist_q   <= '0;
            serial_q <= 1'b0;
            stuff_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            hist_q   <= hist_d;
            serial_q <= serial_d;
            stuff_q  <= stuff_d;
            done_q   <= done_d;
        end
    end
endmodule
